char_rom_shifter: RTL and testbench

- Video pixel stage that sits directly around the character-generator ROM.
- Accepts a character code and scanline row, and drives the ROM address and clock enable.
- Captures the ROM byte and applies inverse/flash attributes.
- Serialises 7 pixels LSB-first on the pixel-clock enable, with one holding register so the next character fetch overlaps the current character's shift-out.

---
 rtl/char_rom_shifter.sv | 122 ++++++++++++
 tb/tb_char_rom_shifter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_rom_shifter.sv
// Character-generator ROM front end: fetches one glyph row, applies inverse/flash, and
// serialises 7 pixels LSB-first. Optional macro ALTCHAR_EN enables the alternate (MouseText) set.
module char_rom_shifter #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic [7:0]    char_code,
  input  logic [2:0]    row,
  input  logic          flash_phase,
  input  logic          altchar,
  input  logic          pix_ce,
  output logic          ready,
  output logic          rom_ce,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_d,
  output logic          pixel,
  output logic          pixel_valid,
  output logic          underrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CAPT  = 2'd2
  } state_t;

  state_t     state;
  logic [6:0] hold;
  logic       hold_valid;
  logic       hold_inv;
  logic [6:0] sreg;
  logic [2:0] bits_left;
  logic       started;

  logic       alt_sel;
  logic       flash_en;
  logic       inv_attr;

`ifdef ALTCHAR_EN
  // The alternate set puts MouseText in the 01xxxxxx range, so flashing is suppressed there.
  assign alt_sel  = altchar;
  assign flash_en = ~altchar;
`else
  logic unused_altchar;
  assign unused_altchar = altchar;
  assign alt_sel  = 1'b0;
  assign flash_en = 1'b1;
`endif

  logic unused_rom_bits;
  assign unused_rom_bits = ^rom_d[DW-1:7];

  assign inv_attr = (char_code[7:6] == 2'b00) |
                    ((char_code[7:6] == 2'b01) & flash_phase & flash_en);

  assign ready       = (state == IDLE) & ~hold_valid;
  assign pixel       = sreg[0];
  assign pixel_valid = (bits_left != 3'd0);

  // Fetch FSM and pixel shifter share hold_valid, so both live in one sequential block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rom_ce     <= 1'b0;
      rom_a      <= '0;
      hold       <= 7'd0;
      hold_valid <= 1'b0;
      hold_inv   <= 1'b0;
      sreg       <= 7'd0;
      bits_left  <= 3'd0;
      underrun   <= 1'b0;
      started    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load && ready) begin
            rom_a    <= AW'({alt_sel, char_code, row});
            rom_ce   <= 1'b1;
            hold_inv <= inv_attr;
            state    <= FETCH;
          end
        end
        FETCH: begin
          rom_ce <= 1'b0;
          state  <= CAPT;
        end
        CAPT: begin
          hold       <= hold_inv ? ~rom_d[6:0] : rom_d[6:0];
          hold_valid <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          rom_ce <= 1'b0;
          state  <= IDLE;
        end
      endcase

      // A fetch only starts with hold empty, so CAPT never sets hold_valid on the edge it is cleared.
      if (pix_ce) begin
        if (bits_left > 3'd1) begin
          sreg      <= {1'b0, sreg[6:1]};
          bits_left <= bits_left - 3'd1;
        end else if (hold_valid) begin
          sreg       <= hold;
          bits_left  <= 3'd7;
          hold_valid <= 1'b0;
          started    <= 1'b1;
        end else begin
          sreg      <= 7'd0;
          bits_left <= 3'd0;
          if (started) begin
            underrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_char_rom_shifter.sv
// Self-checking bench for char_rom_shifter: vector table, pixel scoreboard queue and
// hand-written multi-cycle sequences (stream, load-while-busy, reset mid-fetch).
module tb_char_rom_shifter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  char_code = 8'h00;
  logic [2:0]  row = 3'd0;
  logic        flash_phase = 1'b0;
  logic        altchar = 1'b0;
  logic        pix_ce = 1'b0;
  logic        ready, rom_ce, pixel, pixel_valid, underrun;
  logic [11:0] rom_a;
  logic [7:0]  rom_d = 8'h00;

  int   total = 0;
  int   bad = 0;
  bit   exp_q[$];
  int   popped = 0;
  int   rom_ce_cycles = 0;
  int   cyc = 0;
  int   ce_base = 0;
  logic mon_pce = 1'b0;
  logic rom_over = 1'b0;
  logic [7:0] rom_val = 8'h00;

  typedef struct {
    logic [7:0]  code;
    logic [2:0]  row;
    logic        fp;
    logic        alt;
    logic [7:0]  d;
    logic [11:0] addr;
    logic [6:0]  hold;
  } vec_t;
  vec_t vecs[8];

  char_rom_shifter #(.AW(12), .DW(8)) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .char_code(char_code), .row(row),
    .flash_phase(flash_phase), .altchar(altchar), .pix_ce(pix_ce), .ready(ready),
    .rom_ce(rom_ce), .rom_a(rom_a), .rom_d(rom_d), .pixel(pixel),
    .pixel_valid(pixel_valid), .underrun(underrun)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5C;
  endfunction

  function automatic logic [11:0] m_addr(input logic [7:0] c, input logic [2:0] r, input logic alt);
`ifdef ALTCHAR_EN
    return {alt, c, r};
`else
    return {1'b0 & alt, c, r};
`endif
  endfunction

  function automatic logic [6:0] m_hold(input logic [7:0] c, input logic fp, input logic alt,
                                        input logic [7:0] d);
    logic fl;
    logic inv;
`ifdef ALTCHAR_EN
    fl = !alt;
`else
    fl = 1'b1 | alt;
`endif
    inv = (c[7:6] == 2'b00) || (c[7:6] == 2'b01 && fp && fl);
    return inv ? ~d[6:0] : d[6:0];
  endfunction

  // ROM model: data valid the cycle after rom_ce is sampled high
  always @(posedge clock) begin
    if (rom_ce) rom_d <= rom_over ? rom_val : rom_fn(rom_a);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pixel monitor: every pix_ce edge that leaves a valid pixel pops one expected bit
  always @(posedge clock) begin
    mon_pce = pix_ce;
    if (rom_ce) rom_ce_cycles++;
    #1;
    if (mon_pce && pixel_valid) begin
      chk("pixel_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        chk("pixel", pixel, exp_q.pop_front());
        popped++;
      end
    end
  end

  task automatic push_exp(input logic [6:0] h);
    for (int i = 0; i < 7; i++) exp_q.push_back(h[i]);
  endtask

  task automatic pulse_pix(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock) pix_ce = 1'b1;
      @(negedge clock) pix_ce = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", ready, 1);
  endtask

  task automatic do_load(input logic [7:0] c, input logic [2:0] r, input logic fp, input logic alt);
    wait_ready();
    char_code = c; row = r; flash_phase = fp; altchar = alt; load = 1'b1;
    @(negedge clock) load = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hC1, 3'd3, 1'b0, 1'b0, 8'h55, 12'h60B, 7'h55};
    vecs[1] = '{8'h01, 3'd0, 1'b0, 1'b0, 8'h55, 12'h008, 7'h2A};
    vecs[2] = '{8'h41, 3'd2, 1'b0, 1'b0, 8'h55, 12'h20A, 7'h55};
    vecs[3] = '{8'h41, 3'd2, 1'b1, 1'b0, 8'h55, 12'h20A, 7'h2A};
    vecs[4] = '{8'h81, 3'd7, 1'b1, 1'b0, 8'hD5, 12'h40F, 7'h55};
    vecs[5] = '{8'h3F, 3'd5, 1'b1, 1'b0, 8'h0F, 12'h1FD, 7'h70};
`ifdef ALTCHAR_EN
    vecs[6] = '{8'h41, 3'd1, 1'b1, 1'b1, 8'h55, 12'hA09, 7'h55};
    vecs[7] = '{8'h01, 3'd1, 1'b1, 1'b1, 8'h55, 12'h809, 7'h2A};
`else
    vecs[6] = '{8'h41, 3'd1, 1'b1, 1'b1, 8'h55, 12'h209, 7'h2A};
    vecs[7] = '{8'h01, 3'd1, 1'b1, 1'b1, 8'h55, 12'h009, 7'h2A};
`endif

    // reset held while the pixel clock runs
    pulse_pix(10);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", ready, 1);
    chk("rst_rom_ce", rom_ce, 0);
    chk("rst_rom_a", rom_a, 0);
    @(negedge clock) reset_n = 1'b1;

    // vector table, back-to-back characters
    rom_over = 1'b1;
    for (int v = 0; v < 8; v++) begin
      rom_val = vecs[v].d;
      do_load(vecs[v].code, vecs[v].row, vecs[v].fp, vecs[v].alt);
      chk("fetch_rom_ce_on", rom_ce, 1);
      chk("fetch_rom_a", rom_a, vecs[v].addr);
      @(negedge clock);
      chk("fetch_rom_ce_off", rom_ce, 0);
      chk("capt_rom_a", rom_a, vecs[v].addr);
      @(negedge clock);
      chk("hold_full_not_ready", ready, 0);
      push_exp(vecs[v].hold);
      pulse_pix(7);
      chk("vec_drained", exp_q.size(), 0);
      chk("vec_ready_after_consume", ready, 1);
    end
    chk("vec_no_underrun", underrun, 0);

    // continuous stream after a fresh reset
    @(negedge clock) reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    exp_q.delete();
    popped = 0;
    rom_over = 1'b0;
    fork
      begin
        cyc = 0;
        while (popped < 140 && cyc < 3000) begin
          @(negedge clock);
          pix_ce = (cyc % 2 == 0);
          cyc++;
        end
        @(negedge clock) pix_ce = 1'b0;
      end
      begin
        for (int k = 0; k < 20; k++) begin
          logic [7:0] c;
          logic [2:0] r;
          logic fp, alt;
          c = 8'($urandom); r = 3'($urandom); fp = 1'($urandom); alt = 1'($urandom);
          do_load(c, r, fp, alt);
          push_exp(m_hold(c, fp, alt, rom_fn(m_addr(c, r, alt))));
        end
      end
    join
    chk("stream_pixel_count", popped, 140);
    chk("stream_no_underrun", underrun, 0);
    pulse_pix(1);
    chk("stream_underrun_set", underrun, 1);
    chk("stream_pixel_valid_off", pixel_valid, 0);

    // second load during FETCH and CAPT is ignored
    rom_over = 1'b1;
    rom_val = 8'h55;
    ce_base = rom_ce_cycles;
    do_load(8'hC1, 3'd3, 1'b0, 1'b0);
    char_code = 8'h02; row = 3'd6; load = 1'b1;
    @(negedge clock);
    chk("busy_rom_a_fetch", rom_a, 12'h60B);
    @(negedge clock);
    chk("busy_rom_a_capt", rom_a, 12'h60B);
    chk("busy_ready", ready, 0);
    load = 1'b0;
    push_exp(7'h55);
    pulse_pix(7);
    chk("busy_drained", exp_q.size(), 0);
    chk("busy_single_rom_cycle", rom_ce_cycles - ce_base, 1);
    chk("busy_underrun_sticky", underrun, 1);

    // reset asserted while fetching
    do_load(8'h81, 3'd7, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_rom_ce", rom_ce, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_rom_a", rom_a, 0);
    chk("midrst_pixel_valid", pixel_valid, 0);
    chk("midrst_underrun", underrun, 0);
    @(negedge clock) reset_n = 1'b1;
    exp_q.delete();
    pulse_pix(3);
    chk("midrst_no_pixels", pixel_valid, 0);
    chk("midrst_no_underrun", underrun, 0);
    chk("midrst_ready_after", ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
